// File: rtl/es_ctrl_pkg.sv
// es_ctrl_pkg: shared state encoding for the multiplier sequencing controller.
package es_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_e;
endpackage

// File: rtl/es_mul_seq_ctrl_cnt.sv
// es_mul_seq_ctrl_cnt: clearable up-counter advancing by STRIDE when enabled.
module es_mul_seq_ctrl_cnt #(
  parameter int WIDTH  = 8,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);
  logic [WIDTH-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + WIDTH'(STRIDE);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/es_mul_seq_ctrl.sv
// es_mul_seq_ctrl: sequences one multiplier job through clear, run, drain and result hold.
module es_mul_seq_ctrl
  import es_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int WXIP1      = 1,
  parameter int CYC_W      = 12
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] in_data,
  output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] mul_data,
  output logic                                 mul_clr,
  output logic                                 mul_en,
  input  logic                                 mul_done,
  input  logic [WXIP1-1:0]                     mul_result,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WXIP1-1:0]                     out_data,
  output logic [CYC_W-1:0]                     out_cycles,
  output logic                                 out_err
);
  // the RUN cycle that brings the counter to all-ones is the last one allowed
  localparam logic [CYC_W-1:0] LAST = {{(CYC_W-1){1'b1}}, 1'b0};
  state_e                                 state_q;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  mul_data_q;
  logic                                   mul_clr_q, mul_en_q, out_err_q;
  logic [WXIP1-1:0]                       out_data_q;
  logic [CYC_W-1:0]                       out_cycles_q, cnt;
  es_mul_seq_ctrl_cnt #(.WIDTH(CYC_W), .STRIDE(1)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q == CLEAR),
    .en_i (state_q == RUN && !(&cnt)),
    .cnt_o(cnt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q      <= IDLE;
      mul_data_q   <= '0;
      mul_clr_q    <= 1'b0;
      mul_en_q     <= 1'b0;
      out_err_q    <= 1'b0;
      out_data_q   <= '0;
      out_cycles_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_q    <= CLEAR;
          mul_data_q <= in_data;
          mul_clr_q  <= 1'b1;
        end
        CLEAR: begin
          state_q   <= RUN;
          mul_clr_q <= 1'b0;
          mul_en_q  <= 1'b1;
        end
        RUN: if (mul_done || cnt == LAST) begin
          state_q   <= DRAIN;
          mul_en_q  <= 1'b0;
          out_err_q <= !mul_done;
        end
        DRAIN: begin
          state_q      <= HOLD;
          out_data_q   <= mul_result;
          out_cycles_q <= cnt;
        end
        HOLD: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == HOLD;
  assign mul_data   = mul_data_q;
  assign mul_clr    = mul_clr_q;
  assign mul_en     = mul_en_q;
  assign out_err    = out_err_q;
  assign out_data   = out_data_q;
  assign out_cycles = out_cycles_q;
endmodule
